prbs_rx_monitor: RTL and testbench

- Receive-side partner of the PRBS traffic generator. Sits on the PCS AXIS rx stream in the rx user-clock domain.
- Self-seeds a PRBS31 predictor from the first beat of each frame, then compares every later payload byte against the prediction.
- Reports frame, bit-error, errored-frame and PCS-flagged-error counts, plus a sync indication, for link BER bring-up.

---
 rtl/prbs_pkg.sv | 37 +++
 rtl/prbs31_adv32.sv | 11 +
 rtl/prbs_rx_monitor.sv | 178 +++++++++++++++++
 tb/tb_prbs_rx_monitor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS31 definitions for the rx monitor and the traffic generator:
// tap positions, word geometry, the rx FSM state type and word-level helpers.
package prbs_pkg;

    localparam int PRBS_TAP_A = 31;
    localparam int PRBS_TAP_B = 28;
    localparam int WORD_W     = 32;
    localparam int BYTE_N     = 4;

    typedef enum logic {
        ST_SOF   = 1'b0,
        ST_CHECK = 1'b1
    } rx_state_t;

    // Advance the PRBS31 stream by one 32-bit word. Bit j of the new word is
    // stream bit (k+32+j) = s[k+32+j-31] ^ s[k+32+j-28]; offsets past the
    // previous word fall into already-computed low bits of the new word.
    function automatic logic [WORD_W-1:0] prbs31_advance(input logic [WORD_W-1:0] prev_word);
        logic [2*WORD_W-1:0] s;
        s = {{WORD_W{1'b0}}, prev_word};
        for (int j = 0; j < WORD_W; j++) begin
            s[WORD_W + j] = s[j + WORD_W - PRBS_TAP_A] ^ s[j + WORD_W - PRBS_TAP_B];
        end
        return s[2*WORD_W-1:WORD_W];
    endfunction

    // Number of set bits in a word (0..32).
    function automatic logic [5:0] popcount32(input logic [WORD_W-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < WORD_W; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs31_adv32.sv
// Combinational 32-step PRBS31 advance: previous word in, next word out.
module prbs31_adv32
    import prbs_pkg::*;
(
    input  logic [WORD_W-1:0] prev_word,
    output logic [WORD_W-1:0] next_word
);

    assign next_word = prbs31_advance(prev_word);

endmodule

// File: rtl/prbs_rx_monitor.sv
// PRBS31 receive monitor. Seeds a predictor from the first beat of each frame,
// compares later payload bytes against the prediction and keeps BER counters
// plus a sync indication. Two register stages: stage 1 holds the per-beat
// error mask, stage 2 folds it into the frame and link counters.
module prbs_rx_monitor
    import prbs_pkg::*;
#(
    parameter int LOCK_FRAMES = 4,
    parameter int CNT_W       = 32,
    parameter int FCNT_W      = 16
) (
    input  logic              rx_user_clk_i,
    input  logic              rx_user_rst_i,
    input  logic [31:0]       rx_data_i,
    input  logic [1:0]        rx_vldb_i,
    input  logic              rx_valid_i,
    input  logic              rx_last_i,
    input  logic              rx_user_i,
    input  logic              clr_i,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic [CNT_W-1:0]  err_bit_cnt_o,
    output logic [FCNT_W-1:0] err_frame_cnt_o,
    output logic [FCNT_W-1:0] user_err_cnt_o,
    output logic              sync_o,
    output logic              err_o
);

    localparam logic [7:0] LOCK_RUN = 8'(LOCK_FRAMES);

    // Handshake: a beat is transferred on every clock where rx_valid_i is high;
    // there is no ready, so the monitor must accept every valid beat.

    rx_state_t         state_q, state_d;
    logic [WORD_W-1:0] pred_q;
    logic [WORD_W-1:0] expected;
    logic [WORD_W-1:0] keep;
    logic [WORD_W-1:0] mask;
    logic              seed_load;
    logic              beat_check;
    logic              beat_checked;

    logic              s1_valid;
    logic [WORD_W-1:0] s1_mask;
    logic              s1_last;
    logic              s1_user;
    logic              s1_checked;

    logic              frame_err_seen;
    logic [7:0]        run_q;
    logic [7:0]        run_next;
    logic [5:0]        pop;
    logic [CNT_W:0]    bit_sum;
    logic              frame_bad;

    prbs31_adv32 u_adv (
        .prev_word (pred_q),
        .next_word (expected)
    );

    // FSM state register.
    always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
        if (rx_user_rst_i) state_q <= ST_SOF;
        else               state_q <= state_d;
    end

    // FSM next state and per-beat control: seed on a full first beat, compare in-frame.
    always_comb begin
        state_d      = state_q;
        seed_load    = 1'b0;
        beat_check   = 1'b0;
        beat_checked = 1'b0;
        if (rx_valid_i) begin
            unique case (state_q)
                ST_SOF: begin
                    seed_load    = !rx_last_i || (rx_vldb_i == 2'd3);
                    beat_checked = seed_load;
                    if (!rx_last_i) state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    beat_check   = 1'b1;
                    beat_checked = 1'b1;
                    if (rx_last_i) state_d = ST_SOF;
                end
                default: state_d = ST_SOF;
            endcase
        end
    end

    // Error mask of the current beat, with bytes above vldb dropped on the last beat.
    always_comb begin
        keep = '0;
        for (int b = 0; b < BYTE_N; b++) begin
            keep[b*8 +: 8] = (!rx_last_i || (2'(b) <= rx_vldb_i)) ? 8'hFF : 8'h00;
        end
        mask = beat_check ? ((rx_data_i ^ expected) & keep) : '0;
    end

    // Predictor: reseeded from received data at frame start, then free-runs on its own prediction.
    always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
        if (rx_user_rst_i)   pred_q <= '0;
        else if (seed_load)  pred_q <= rx_data_i;
        else if (beat_check) pred_q <= expected;
    end

    // Stage 1: register the beat's error mask and frame-end attributes.
    always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
        if (rx_user_rst_i) begin
            s1_valid   <= 1'b0;
            s1_mask    <= '0;
            s1_last    <= 1'b0;
            s1_user    <= 1'b0;
            s1_checked <= 1'b0;
        end else if (clr_i) begin
            s1_valid   <= 1'b0;
            s1_mask    <= '0;
            s1_last    <= 1'b0;
            s1_user    <= 1'b0;
            s1_checked <= 1'b0;
        end else begin
            s1_valid   <= rx_valid_i;
            s1_mask    <= mask;
            s1_last    <= rx_valid_i && rx_last_i;
            s1_user    <= rx_valid_i && rx_last_i && rx_user_i;
            s1_checked <= beat_checked;
        end
    end

    // Stage 2 arithmetic: bit-error sum with carry for saturation, frame verdict, next run length.
    always_comb begin
        pop       = popcount32(s1_mask);
        bit_sum   = {1'b0, err_bit_cnt_o} + (CNT_W+1)'(pop);
        frame_bad = frame_err_seen || (pop != 6'd0) || s1_user;
        run_next  = (run_q == LOCK_RUN) ? run_q : run_q + 8'd1;
    end

    // Stage 2: saturating counters, errored-frame pulse and clean-frame run length.
    always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
        if (rx_user_rst_i) begin
            frame_cnt_o     <= '0;
            err_bit_cnt_o   <= '0;
            err_frame_cnt_o <= '0;
            user_err_cnt_o  <= '0;
            err_o           <= 1'b0;
            run_q           <= '0;
            frame_err_seen  <= 1'b0;
        end else if (clr_i) begin
            frame_cnt_o     <= '0;
            err_bit_cnt_o   <= '0;
            err_frame_cnt_o <= '0;
            user_err_cnt_o  <= '0;
            err_o           <= 1'b0;
            run_q           <= '0;
            frame_err_seen  <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (s1_valid) begin
                err_bit_cnt_o <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
                if (s1_last) begin
                    frame_err_seen <= 1'b0;
                    if (frame_cnt_o != '1) frame_cnt_o <= frame_cnt_o + 1'b1;
                    if (s1_user && (user_err_cnt_o != '1)) user_err_cnt_o <= user_err_cnt_o + 1'b1;
                    if (frame_bad) begin
                        if (err_frame_cnt_o != '1) err_frame_cnt_o <= err_frame_cnt_o + 1'b1;
                        err_o <= 1'b1;
                        run_q <= '0;
                    end else if (s1_checked) begin
                        run_q <= run_next;
                    end
                end else begin
                    frame_err_seen <= frame_bad;
                end
            end
        end
    end

    assign sync_o = (run_q == LOCK_RUN);

endmodule

// File: tb/tb_prbs_rx_monitor.sv
// Directed bench for prbs_rx_monitor: a frame-level reference model is fed
// with the bit errors the driver deliberately injects, and every output is
// compared against it each cycle, alongside hand-computed totals.
module tb_prbs_rx_monitor;

    localparam int LOCK_FRAMES = 4;
    localparam int CNT_W       = 32;
    localparam int FCNT_W      = 16;
    localparam longint CNT_MAX  = (64'd1 << CNT_W) - 1;
    localparam longint FCNT_MAX = (64'd1 << FCNT_W) - 1;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]       rx_data  = '0;
    logic [1:0]        rx_vldb  = '0;
    logic              rx_valid = 1'b0;
    logic              rx_last  = 1'b0;
    logic              rx_user  = 1'b0;
    logic              clr      = 1'b0;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_bit_cnt;
    logic [FCNT_W-1:0] err_frame_cnt;
    logic [FCNT_W-1:0] user_err_cnt;
    logic              sync;
    logic              err;

    prbs_rx_monitor #(
        .LOCK_FRAMES (LOCK_FRAMES),
        .CNT_W       (CNT_W),
        .FCNT_W      (FCNT_W)
    ) dut (
        .rx_user_clk_i   (clk),
        .rx_user_rst_i   (rst),
        .rx_data_i       (rx_data),
        .rx_vldb_i       (rx_vldb),
        .rx_valid_i      (rx_valid),
        .rx_last_i       (rx_last),
        .rx_user_i       (rx_user),
        .clr_i           (clr),
        .frame_cnt_o     (frame_cnt),
        .err_bit_cnt_o   (err_bit_cnt),
        .err_frame_cnt_o (err_frame_cnt),
        .user_err_cnt_o  (user_err_cnt),
        .sync_o          (sync),
        .err_o           (err)
    );

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    // Per-beat description from the driver: injected bit errors that fall in
    // the compared region, and whether the frame is a checked one.
    int desc_bits    = 0;
    bit desc_checked = 1'b0;

    logic [31:0] cur_word = 32'hACE1_2345;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // PRBS31 stream generated bit by bit from s[n] = s[n-31] ^ s[n-28].
    function automatic logic [31:0] prbs_next(input logic [31:0] prev);
        bit          s[$];
        logic [31:0] r;
        int          n;
        r = '0;
        for (int i = 0; i < 32; i++) s.push_back(prev[i]);
        for (int i = 0; i < 32; i++) begin
            n = s.size();
            s.push_back(s[n-31] ^ s[n-28]);
            r[i] = s[n];
        end
        return r;
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input longint mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    // Reference model: a beat taken at one edge shows in the outputs after the next edge.
    longint m_frame, m_bits, m_eframe, m_uerr;
    int     m_run;
    bit     m_err;
    bit     p_valid, p_last, p_user, p_checked, frame_bad;
    int     p_bits;

    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            m_frame = 0; m_bits = 0; m_eframe = 0; m_uerr = 0;
            m_run = 0; m_err = 0; p_valid = 0; frame_bad = 0;
        end else begin
            m_err = 0;
            if (p_valid) begin
                m_bits = sat_add(m_bits, p_bits, CNT_MAX);
                frame_bad = frame_bad || (p_bits > 0);
                if (p_last) begin
                    m_frame = sat_add(m_frame, 1, CNT_MAX);
                    if (p_user) m_uerr = sat_add(m_uerr, 1, FCNT_MAX);
                    if (frame_bad || p_user) begin
                        m_eframe = sat_add(m_eframe, 1, FCNT_MAX);
                        m_err = 1;
                        m_run = 0;
                    end else if (p_checked && m_run < LOCK_FRAMES) begin
                        m_run++;
                    end
                    frame_bad = 0;
                end
            end
            p_valid = rx_valid;
        end
        p_last    = rx_last;
        p_user    = rx_user;
        p_bits    = desc_bits;
        p_checked = desc_checked;
    end

    // Scoreboard compare on the falling edge, every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("frame_cnt", frame_cnt, m_frame);
            chk("err_bit_cnt", err_bit_cnt, m_bits);
            chk("err_frame_cnt", err_frame_cnt, m_eframe);
            chk("user_err_cnt", user_err_cnt, m_uerr);
            chk("sync", sync, (m_run == LOCK_FRAMES) ? 1 : 0);
            chk("err_pulse", err, m_err);
            if (err) err_pulses++;
        end
    end

    // Driver tasks: called just after a rising edge, return just after the edge that took the beat.
    task automatic drive_beat(input logic [31:0] data, input logic [1:0] vldb, input bit last,
                              input bit user, input int bits, input bit checked);
        rx_valid = 1'b1; rx_data = data; rx_vldb = vldb; rx_last = last; rx_user = user;
        desc_bits = bits; desc_checked = checked;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_last = 1'b0; rx_user = 1'b0; desc_bits = 0; desc_checked = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int nbeats, input logic [1:0] vldb_last, input bit user,
                              input int flip_beat, input logic [31:0] flip);
        logic [31:0] keep, fm;
        logic [1:0]  v;
        bit          last;
        int          bits;
        for (int b = 0; b < nbeats; b++) begin
            last = (b == nbeats - 1);
            v    = last ? vldb_last : 2'd3;
            keep = '0;
            for (int k = 0; k <= int'(v); k++) keep[k*8 +: 8] = 8'hFF;
            fm   = (b == flip_beat) ? flip : 32'h0;
            bits = (b > 0) ? $countones(fm & keep) : 0;
            drive_beat(cur_word ^ fm, v, last, user && last, bits, (nbeats > 1) || (vldb_last == 2'd3));
            cur_word = prbs_next(cur_word);
        end
    endtask

    task automatic chk_totals(input string tag, input longint f, input longint b,
                              input longint ef, input longint ue, input bit s);
        chk({tag, "_frames"}, frame_cnt, f);
        chk({tag, "_bits"}, err_bit_cnt, b);
        chk({tag, "_eframes"}, err_frame_cnt, ef);
        chk({tag, "_uerr"}, user_err_cnt, ue);
        chk({tag, "_sync"}, sync, s);
    endtask

    initial begin
        // Pin the reference generator to hand-derived advances.
        chk("prbs_pin_a", prbs_next(32'h8000_0000), 32'h4800_0000);
        chk("prbs_pin_b", prbs_next(32'h0000_0010), 32'h1000_0009);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_totals("reset", 0, 0, 0, 0, 0);
        chk("reset_err", err, 0);
        idle(3);
        chk_totals("idle", 0, 0, 0, 0, 0);

        // Eight clean back-to-back frames; sync lands after the fourth.
        for (int f = 0; f < 8; f++) begin
            send_frame(16, 2'd3, 1'b0, -1, 32'h0);
            if (f == 3) chk("sync_before_lock", sync, 0);
            if (f == 4) chk("sync_after_lock", sync, 1);
        end
        idle(2);
        chk_totals("clean8", 8, 0, 0, 0, 1);

        // Two flipped bits in beat 7, then recovery over four clean frames.
        send_frame(16, 2'd3, 1'b0, 7, (32'h1 << 5) | (32'h1 << 17));
        for (int f = 0; f < 3; f++) send_frame(16, 2'd3, 1'b0, -1, 32'h0);
        chk("sync_relock_pending", sync, 0);
        send_frame(16, 2'd3, 1'b0, -1, 32'h0);
        idle(2);
        chk_totals("flip2", 13, 2, 1, 0, 1);
        chk("pulses_flip2", err_pulses, 1);

        // Partial last beat: byte above vldb ignored, byte inside counted.
        send_frame(4, 2'd1, 1'b0, 3, 32'hFF00_0000);
        idle(2);
        chk_totals("vldb_masked", 14, 2, 1, 0, 1);
        send_frame(4, 2'd1, 1'b0, 3, 32'h0000_FF00);
        idle(2);
        chk_totals("vldb_byte1", 15, 10, 2, 0, 0);

        // One-beat short frame flagged by the PCS.
        send_frame(2, 2'd3, 1'b0, -1, 32'h0);
        send_frame(1, 2'd0, 1'b1, -1, 32'h0);
        idle(2);
        chk_totals("user_flag", 17, 10, 3, 1, 0);
        chk("pulses_user", err_pulses, 3);

        // Clear coincides with a corrupted frame completing.
        send_frame(4, 2'd3, 1'b0, 2, 32'h0000_0001);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk_totals("clr", 0, 0, 0, 0, 0);
        chk("clr_err", err, 0);
        idle(2);
        chk_totals("clr_after", 0, 0, 0, 0, 0);

        // Reset mid-frame, then the same stream continues.
        for (int b = 0; b < 6; b++) begin
            drive_beat(cur_word, 2'd3, 1'b0, 1'b0, 0, 1'b1);
            cur_word = prbs_next(cur_word);
        end
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int b = 6; b < 16; b++) begin
            drive_beat(cur_word, 2'd3, b == 15, 1'b0, 0, 1'b1);
            cur_word = prbs_next(cur_word);
        end
        send_frame(16, 2'd3, 1'b0, -1, 32'h0);
        idle(2);
        chk_totals("rst_mid", 2, 0, 0, 0, 0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
